// File: rtl/level_controller.sv
// Game-progress sequencer: level, lives, win/lose and the frame-timed level-start hold.
// Optional LEVEL_CTRL_EXTRA_LIFE_EN grants one life (max 7) per non-final level cleared.
module level_controller #(
    parameter int TARGETS_PER_LEVEL = 5,
    parameter int NUM_LEVELS        = 4,
    parameter int LIVES             = 3,
    parameter int RESET_HOLD_FRAMES = 60,
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             targetHit,
    input  logic             ballLost,
    input  logic             restart,
    output logic             reset_level,
    output logic [LVL_W-1:0] level,
    output logic [2:0]       lives,
    output logic             gameOver,
    output logic             gameWon
);

    localparam int HIT_W = $clog2(TARGETS_PER_LEVEL + 1);
    localparam int FRM_W = $clog2(RESET_HOLD_FRAMES + 1);

    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(TARGETS_PER_LEVEL - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(RESET_HOLD_FRAMES - 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS - 1);
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

    typedef enum logic [1:0] {
        LEVEL_RESET = 2'd0,
        PLAY        = 2'd1,
        GAME_OVER   = 2'd2,
        WIN         = 2'd3
    } state_t;

    state_t             r_state;
    logic [HIT_W-1:0]   r_hitCnt;
    logic [FRM_W-1:0]   r_frameCnt;

    logic w_lastFrame;
    logic w_lastHit;
    logic w_lastLevel;
    logic w_lastLife;

    assign w_lastFrame = (r_frameCnt == FRM_LAST);
    assign w_lastHit   = (r_hitCnt == HIT_LAST);
    assign w_lastLevel = (level == LVL_LAST);
    assign w_lastLife  = (lives == 3'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= LEVEL_RESET;
            r_hitCnt    <= '0;
            r_frameCnt  <= '0;
            reset_level <= 1'b1;
            level       <= '0;
            lives       <= LIVES_INIT;
            gameOver    <= 1'b0;
            gameWon     <= 1'b0;
        end else begin
            unique case (r_state)
                LEVEL_RESET: begin
                    if (startOfFrame) begin
                        if (w_lastFrame) begin
                            r_state     <= PLAY;
                            r_frameCnt  <= '0;
                            reset_level <= 1'b0;
                        end else begin
                            r_frameCnt <= r_frameCnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // A drain wins over a simultaneous hit; that hit is lost.
                    if (ballLost) begin
                        r_hitCnt <= '0;
                        lives    <= lives - 1'b1;
                        if (w_lastLife) begin
                            r_state  <= GAME_OVER;
                            gameOver <= 1'b1;
                        end else begin
                            r_state     <= LEVEL_RESET;
                            reset_level <= 1'b1;
                        end
                    end else if (targetHit) begin
                        if (w_lastHit) begin
                            r_hitCnt <= '0;
                            if (w_lastLevel) begin
                                r_state <= WIN;
                                gameWon <= 1'b1;
                            end else begin
                                r_state     <= LEVEL_RESET;
                                reset_level <= 1'b1;
                                level       <= level + 1'b1;
`ifdef LEVEL_CTRL_EXTRA_LIFE_EN
                                if (lives != 3'd7) begin
                                    lives <= lives + 1'b1;
                                end
`endif
                            end
                        end else begin
                            r_hitCnt <= r_hitCnt + 1'b1;
                        end
                    end
                end
                GAME_OVER, WIN: begin
                    if (restart) begin
                        r_state     <= LEVEL_RESET;
                        r_hitCnt    <= '0;
                        r_frameCnt  <= '0;
                        reset_level <= 1'b1;
                        level       <= '0;
                        lives       <= LIVES_INIT;
                        gameOver    <= 1'b0;
                        gameWon     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LEVEL_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_controller.sv
// Directed self-checking bench for level_controller (default parameters).
// Expected lives follow LEVEL_CTRL_EXTRA_LIFE_EN when that macro is defined.
module tb_level_controller;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       targetHit = 1'b0;
    logic       ballLost = 1'b0;
    logic       restart = 1'b0;
    logic       reset_level;
    logic [1:0] level;
    logic [2:0] lives;
    logic       gameOver;
    logic       gameWon;

    int n_checks = 0;
    int n_errors = 0;
    int exp_lives;

    level_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .targetHit    (targetHit),
        .ballLost     (ballLost),
        .restart      (restart),
        .reset_level  (reset_level),
        .level        (level),
        .lives        (lives),
        .gameOver     (gameOver),
        .gameWon      (gameWon)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Back-to-back pulses, n consecutive sampled edges; returns at a negedge.
    task automatic frames(input int n);
        @(negedge clk) startOfFrame = 1'b1;
        repeat (n) @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic hits(input int n);
        @(negedge clk) targetHit = 1'b1;
        repeat (n) @(negedge clk);
        targetHit = 1'b0;
    endtask

    task automatic lose();
        @(negedge clk) ballLost = 1'b1;
        @(negedge clk) ballLost = 1'b0;
    endtask

    function automatic int bonus(input int l);
`ifdef LEVEL_CTRL_EXTRA_LIFE_EN
        return (l < 7) ? l + 1 : l;
`else
        return l;
`endif
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_reset_level", reset_level, 1);
        chk("rst_level", level, 0);
        chk("rst_lives", lives, 3);
        chk("rst_gameOver", gameOver, 0);
        chk("rst_gameWon", gameWon, 0);
        resetN = 1'b1;
        exp_lives = 3;

        // Hits during the hold must be ignored.
        hits(5);
        chk("hold_hit_ignored", level, 0);
        frames(59);
        chk("hold_59", reset_level, 1);
        frames(1);
        chk("hold_60", reset_level, 0);
        chk("hold_level", level, 0);
        chk("hold_lives", lives, 3);

        hits(4);
        chk("hit4_level", level, 0);
        chk("hit4_reset_level", reset_level, 0);
        hits(1);
        exp_lives = bonus(exp_lives);
        chk("hit5_level", level, 1);
        chk("hit5_reset_level", reset_level, 1);
        chk("hit5_lives", lives, exp_lives);
        frames(60);
        chk("l1_play", reset_level, 0);

        for (int i = 0; i < 8 && exp_lives > 0; i++) begin
            lose();
            exp_lives--;
            chk("lost_lives", lives, exp_lives);
            if (exp_lives > 0) begin
                chk("lost_reset_level", reset_level, 1);
                chk("lost_level", level, 1);
                frames(60);
                chk("lost_rehold", reset_level, 0);
            end else begin
                chk("over_gameOver", gameOver, 1);
                chk("over_reset_level", reset_level, 0);
            end
        end

        hits(6);
        frames(3);
        lose();
        chk("over_ignored_level", level, 1);
        chk("over_ignored_lives", lives, 0);
        chk("over_ignored_gameOver", gameOver, 1);

        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        exp_lives = 3;
        chk("restart_lives", lives, 3);
        chk("restart_level", level, 0);
        chk("restart_reset_level", reset_level, 1);
        chk("restart_gameOver", gameOver, 0);

        frames(60);
        hits(4);
        @(negedge clk) begin
            targetHit = 1'b1;
            ballLost  = 1'b1;
        end
        @(negedge clk) begin
            targetHit = 1'b0;
            ballLost  = 1'b0;
        end
        exp_lives--;
        chk("both_lives", lives, exp_lives);
        chk("both_level", level, 0);
        chk("both_reset_level", reset_level, 1);
        frames(60);
        hits(4);
        chk("both_hitcnt_cleared", level, 0);
        hits(1);
        exp_lives = bonus(exp_lives);
        chk("after_both_level", level, 1);
        chk("after_both_lives", lives, exp_lives);
        frames(60);
        hits(5);
        chk("l2_level", level, 2);

        frames(30);
        chk("mid_hold", reset_level, 1);
        #2 resetN = 1'b0;
        #1;
        chk("async_level", level, 0);
        chk("async_lives", lives, 3);
        chk("async_reset_level", reset_level, 1);
        @(negedge clk) resetN = 1'b1;
        exp_lives = 3;
        frames(59);
        chk("rehold_59", reset_level, 1);
        frames(1);
        chk("rehold_60", reset_level, 0);

        for (int lv = 0; lv < 4; lv++) begin
            hits(5);
            if (lv < 3) begin
                exp_lives = bonus(exp_lives);
                chk("clear_level", level, lv + 1);
                chk("clear_reset_level", reset_level, 1);
                chk("clear_gameWon", gameWon, 0);
                frames(60);
            end else begin
                chk("win_gameWon", gameWon, 1);
                chk("win_level", level, 3);
                chk("win_reset_level", reset_level, 0);
            end
        end
        chk("win_lives", lives, exp_lives);

        hits(3);
        lose();
        frames(2);
        chk("win_ignored_level", level, 3);
        chk("win_ignored_lives", lives, exp_lives);
        chk("win_ignored_gameWon", gameWon, 1);
        chk("win_ignored_gameOver", gameOver, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
